// File: rtl/reg_file_param.sv
// reg_file_param: parametrised register file with PC mapped at the top address, a per-register
// pending scoreboard and a clear sequencer. Define REG_FILE_BYPASS_EN for same-cycle write bypass.
module reg_file_param #(
    parameter  int unsigned DATA_W = 32,
    parameter  int unsigned NREGS  = 16,
    parameter  int unsigned PC_W   = 13,
    localparam int unsigned AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     ra1,
    input  logic [AW-1:0]     ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic [AW-1:0]     wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              we,
    input  logic [PC_W-1:0]   pc,
    input  logic              pend_set,
    input  logic [AW-1:0]     pend_addr,
    output logic              pend1,
    output logic              pend2,
    input  logic              clr_req,
    output logic              clr_busy
);

    localparam logic [AW-1:0] PC_ADDR  = AW'(NREGS - 1);
    localparam logic [AW-1:0] LAST_CLR = AW'(NREGS - 2);

    typedef enum logic {IDLE, SWEEP} state_e;

    // Top entry exists only to keep indexing full-width; it is never written.
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [NREGS-1:0]  pend_q, pend_d;
    state_e            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic              clr_busy_q, clr_busy_d;

    logic wr_ok, ps_ok;

    assign wr_ok    = we && !clr_busy_q && (wa != PC_ADDR);
    assign ps_ok    = pend_set && !clr_busy_q && (pend_addr != PC_ADDR);
    assign clr_busy = clr_busy_q;

    always_comb begin
        regs_d     = regs_q;
        pend_d     = pend_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_busy_d = clr_busy_q;
        if (state_q == IDLE) begin
            if (wr_ok) begin
                regs_d[wa] = wd;
                pend_d[wa] = 1'b0;
            end
            // Set is applied after the write's clear so it wins on the same address.
            if (ps_ok) begin
                pend_d[pend_addr] = 1'b1;
            end
            if (clr_req) begin
                state_d    = SWEEP;
                cnt_d      = '0;
                clr_busy_d = 1'b1;
            end
        end else begin
            regs_d[cnt_q] = '0;
            pend_d[cnt_q] = 1'b0;
            if (cnt_q == LAST_CLR) begin
                state_d    = IDLE;
                cnt_d      = '0;
                clr_busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            clr_busy_q <= 1'b0;
            pend_q     <= '0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clr_busy_q <= clr_busy_d;
            pend_q     <= pend_d;
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        rd1   = (ra1 == PC_ADDR) ? DATA_W'(pc) : regs_q[ra1];
        rd2   = (ra2 == PC_ADDR) ? DATA_W'(pc) : regs_q[ra2];
        pend1 = (ra1 != PC_ADDR) && pend_q[ra1];
        pend2 = (ra2 != PC_ADDR) && pend_q[ra2];
`ifdef REG_FILE_BYPASS_EN
        if (wr_ok && (wa == ra1)) begin
            rd1   = wd;
            pend1 = pend1 && ps_ok && (pend_addr == ra1);
        end
        if (wr_ok && (wa == ra2)) begin
            rd2   = wd;
            pend2 = pend2 && ps_ok && (pend_addr == ra2);
        end
`endif
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed testbench for reg_file_param: default 16x32 instance plus an 8x16 instance.
module tb_reg_file_param;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [3:0]  ra1, ra2, wa, pend_addr;
    logic [31:0] rd1, rd2, wd;
    logic        we, pend_set, pend1, pend2, clr_req, clr_busy;
    logic [12:0] pc;

    logic [2:0]  b_ra1, b_ra2, b_wa, b_pend_addr;
    logic [15:0] b_rd1, b_rd2, b_wd;
    logic        b_we, b_pend_set, b_pend1, b_pend2, b_clr_req, b_clr_busy;
    logic [7:0]  b_pc;

    reg_file_param dut_a (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .wa(wa), .wd(wd), .we(we), .pc(pc), .pend_set(pend_set), .pend_addr(pend_addr),
        .pend1(pend1), .pend2(pend2), .clr_req(clr_req), .clr_busy(clr_busy)
    );

    reg_file_param #(.DATA_W(16), .NREGS(8), .PC_W(8)) dut_b (
        .clk(clk), .rst(rst), .ra1(b_ra1), .ra2(b_ra2), .rd1(b_rd1), .rd2(b_rd2),
        .wa(b_wa), .wd(b_wd), .we(b_we), .pc(b_pc), .pend_set(b_pend_set),
        .pend_addr(b_pend_addr), .pend1(b_pend1), .pend2(b_pend2),
        .clr_req(b_clr_req), .clr_busy(b_clr_busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b0;
        ra1 = '0; ra2 = '0; wa = '0; wd = '0; we = 1'b0; pend_set = 1'b0; pend_addr = '0;
        clr_req = 1'b0; pc = 13'h1ABC;
        b_ra1 = '0; b_ra2 = '0; b_wa = '0; b_wd = '0; b_we = 1'b0; b_pend_set = 1'b0;
        b_pend_addr = '0; b_clr_req = 1'b0; b_pc = 8'hA5;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Reset state
        for (int i = 0; i < 16; i++) begin
            ra1 = 4'(i); ra2 = 4'(15 - i); #1;
            check("rst_rd1", rd1, (i == 15) ? 32'h00001ABC : 32'h0);
            check("rst_rd2", rd2, (i == 0) ? 32'h00001ABC : 32'h0);
            check("rst_pend1", pend1, 1'b0);
            check("rst_pend2", pend2, 1'b0);
        end
        check("rst_busy", clr_busy, 1'b0);

        // Write and same-cycle read
        step();
        we = 1'b1; wa = 4'd3; wd = 32'hDEADBEEF; ra1 = 4'd3; #1;
        check("wr_same_cycle", rd1, BYP ? 32'hDEADBEEF : 32'h0);
        step();
        we = 1'b0;
        check("wr_next_cycle", rd1, 32'hDEADBEEF);
        we = 1'b1; wa = 4'd15; wd = 32'h1; ra2 = 4'd15;
        step();
        we = 1'b0;
        check("wr_pc_ignored", rd2, 32'h00001ABC);

        // Scoreboard
        ra1 = 4'd5; pend_set = 1'b1; pend_addr = 4'd5; #1;
        check("pend_before_edge", pend1, 1'b0);
        step();
        check("pend_set", pend1, 1'b1);
        we = 1'b1; wa = 4'd5; wd = 32'h0000_5555; #1;
        check("pend_set_wins_same", pend1, 1'b1);
        step();
        we = 1'b0; pend_set = 1'b0;
        check("pend_set_wins_next", pend1, 1'b1);
        check("pend_wr_data", rd1, 32'h0000_5555);
        we = 1'b1; wa = 4'd5; wd = 32'h0000_6666; #1;
        check("pend_clr_same", pend1, BYP ? 1'b0 : 1'b1);
        step();
        we = 1'b0;
        check("pend_clr_next", pend1, 1'b0);
        ra2 = 4'd7; pend_set = 1'b1; pend_addr = 4'd7;
        step();
        check("pend2_set", pend2, 1'b1);
        ra1 = 4'd15; pend_addr = 4'd15;
        step();
        pend_set = 1'b0;
        check("pend_pc_ignored", pend1, 1'b0);

        // Fill, mark r9 pending, then sweep
        for (int i = 0; i < 15; i++) begin
            we = 1'b1; wa = 4'(i); wd = 32'h1000_0000 + 32'(i + 1);
            step();
        end
        we = 1'b0;
        pend_set = 1'b1; pend_addr = 4'd9;
        step();
        pend_set = 1'b0;
        ra1 = 4'd9; #1;
        check("pre_sweep_pend9", pend1, 1'b1);
        check("pre_sweep_r9", rd1, 32'h1000_000A);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        n = 0;
        while (clr_busy && n < 40) begin
            ra2 = 4'(n); ra1 = (n > 0) ? 4'(n - 1) : 4'd15; #1;
            check("sweep_not_yet", rd2, 32'h1000_0000 + 32'(n + 1));
            check("sweep_below", rd1, (n > 0) ? 32'h0 : 32'h00001ABC);
            if (n == 4) begin
                we = 1'b1; wa = 4'd2; wd = 32'hFFFF_FFFF;
                pend_set = 1'b1; pend_addr = 4'd2; clr_req = 1'b1;
            end
            step();
            we = 1'b0; pend_set = 1'b0; clr_req = 1'b0;
            n++;
        end
        check("sweep_len", 64'(n), 64'd15);
        step();
        check("sweep_req_dropped", clr_busy, 1'b0);
        for (int i = 0; i < 15; i++) begin
            ra1 = 4'(i); #1;
            check("sweep_zero", rd1, 32'h0);
            check("sweep_pend_zero", pend1, 1'b0);
        end

        // Reset mid-sweep
        for (int i = 0; i < 15; i++) begin
            we = 1'b1; wa = 4'(i); wd = 32'h2000_0000 + 32'(i + 1);
            step();
        end
        we = 1'b0; clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (7) step();
        check("midsweep_busy", clr_busy, 1'b1);
        rst = 1'b0; #1;
        check("midrst_busy", clr_busy, 1'b0);
        for (int i = 0; i < 16; i++) begin
            ra1 = 4'(i); #1;
            check("midrst_rd", rd1, (i == 15) ? 32'h00001ABC : 32'h0);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        we = 1'b1; wa = 4'd0; wd = 32'hA;
        step();
        wa = 4'd1; wd = 32'hB;
        step();
        we = 1'b0; clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        ra1 = 4'd0; ra2 = 4'd1; #1;
        check("restart_busy", clr_busy, 1'b1);
        check("restart_r0_kept", rd1, 32'hA);
        step();
        check("restart_r0_clr", rd1, 32'h0);
        check("restart_r1_kept", rd2, 32'hB);
        n = 0;
        while (clr_busy && n < 40) begin
            step();
            n++;
        end
        check("restart_len", 64'(n), 64'd14);
        we = 1'b1; wa = 4'd0; wd = 32'h55;
        step();
        we = 1'b0; ra1 = 4'd0; #1;
        check("post_sweep_wr", rd1, 32'h55);

        // Narrow instance
        b_ra1 = 3'd7; b_ra2 = 3'd6; #1;
        check("b_pc", 64'(b_rd1), 64'h00A5);
        check("b_r6_rst", 64'(b_rd2), 64'h0);
        b_we = 1'b1; b_wa = 3'd6; b_wd = 16'hBEEF;
        b_pend_set = 1'b1; b_pend_addr = 3'd7;
        step();
        b_we = 1'b0; b_pend_set = 1'b0;
        check("b_wr", 64'(b_rd2), 64'hBEEF);
        check("b_pend_pc", b_pend1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            b_we = 1'b1; b_wa = 3'(i); b_wd = 16'h100 + 16'(i);
            step();
        end
        b_we = 1'b0; b_clr_req = 1'b1;
        step();
        b_clr_req = 1'b0;
        n = 0;
        while (b_clr_busy && n < 40) begin
            step();
            n++;
        end
        check("b_sweep_len", 64'(n), 64'd7);
        for (int i = 0; i < 8; i++) begin
            b_ra1 = 3'(i); #1;
            check("b_sweep_rd", 64'(b_rd1), (i == 7) ? 64'h00A5 : 64'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_file_param.md
# reg_file_param

Parametrised successor register file for the microcontroller datapath: configurable data width and register count, two combinational read ports, one synchronous write port, and a read-only program-counter register at the top address. Adds a per-register pending scoreboard for hazard detection, optional write-to-read bypass, and a hardware clear sequencer that zeroes the file without a reset. It sits between decode and execute, in the same place as the fixed 16×32 register file.

## Interface
- DATA_W, 32, register width in bits
- NREGS, 16, number of architectural registers including the PC register; power of two, ≥4
- PC_W, 13, program-counter width; PC_W ≤ DATA_W
- AW (localparam), $clog2(NREGS), address width
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- ra1, ra2  in  AW  read addresses
- rd1, rd2  out  DATA_W  read data
- wa  in  AW  write address
- wd  in  DATA_W  write data
- we  in  1  write enable
- pc  in  PC_W  current PC, mapped to register NREGS-1
- pend_set  in  1  mark pend_addr pending (producer issued)
- pend_addr  in  AW  register to mark
- pend1, pend2  out  1  pending bit of ra1 / ra2
- clr_req  in  1  start clear sweep
- clr_busy  out  1  sweep in progress

## Operation
- Storage: registers 0..NREGS-2, each DATA_W bits. Register NREGS-1 is not stored; reads return {zeros, pc}. Writes and pend_set to NREGS-1 are ignored.
- Read: rd1 = value(ra1), rd2 = value(ra2), combinational.
- Write: when we=1, clr_busy=0 and wa≠NREGS-1, reg[wa] ← wd at the clock edge.
- Scoreboard: one pending bit per stored register. An accepted write clears pending[wa]. pend_set (clr_busy=0, pend_addr≠NREGS-1) sets pending[pend_addr]. Set and clear on the same address in the same cycle: set wins. pend1/pend2 are combinational and are always 0 for NREGS-1.
- Clear sequencer FSM:
  - IDLE: clr_req=1 → SWEEP, cnt←0.
  - SWEEP: each cycle reg[cnt]←0 and pending[cnt]←0, then cnt←cnt+1. When cnt=NREGS-2, perform the last clear and go to IDLE.
  - The sweep takes exactly NREGS-1 cycles. clr_busy=1 for the whole of SWEEP.
- While clr_busy=1: we, pend_set and clr_req are ignored (dropped, not queued). Reads return current contents, so already-swept registers read 0. Sweep writes are never bypassed.
- cnt width is AW. It never wraps, because the sweep terminates at NREGS-2.

## Timing
- Read latency is 0 cycles. A write becomes visible on the read ports on the cycle after the edge (or the same cycle with bypass; see Configuration).
- A pending set or clear is visible on pend1/pend2 on the cycle after the edge.
- clr_busy rises on the edge that samples clr_req and falls on the edge that performs the NREGS-2 clear.
- The first edge after clr_busy falls accepts we, pend_set and clr_req normally.
- Reset (rst=0, any time, including mid-sweep): all stored registers 0, all pending bits 0, FSM→IDLE, cnt 0, clr_busy 0. Read outputs follow the contents, so they are 0 except at address NREGS-1, which returns pc.

## Configuration
- REG_FILE_BYPASS_EN defined: if we=1, clr_busy=0, wa=raN and wa≠NREGS-1, then rdN = wd in the same cycle. Likewise, if an accepted write targets raN, pendN reads 0 in that cycle unless pend_set targets the same address.
- Not defined: reads return stored contents only. A same-cycle write is seen one cycle later.

## Test plan
- Reset, then read all addresses with pc=13'h1ABC → rd=0 for 0..14, rd=32'h00001ABC at address 15. pend1=pend2=0 and clr_busy=0.
- Write 32'hDEADBEEF to r3 with ra1=3 in the same cycle → rd1=0 that cycle without the macro (DEADBEEF with the macro), and DEADBEEF the next cycle. A write of 1 to r15 leaves rd=pc.
- pend_set r5, then in the next cycle write r5 together with pend_set r5 → pend1 (ra1=5) stays 1. A later write to r5 alone → pend1=0 on the next cycle.
- Fill r0..r14 with nonzero values and pulse clr_req → clr_busy high for exactly 15 cycles, regs read 0 in ascending order, and a we to r2 during the sweep is dropped (r2=0 after).
- Deassert rst mid-sweep at cycle 7 → all regs 0, clr_busy 0 immediately. A new clr_req after release restarts the sweep at r0.
- Parameter sweep DATA_W=16, NREGS=8, PC_W=8 → PC register at address 7, sweep lasts 7 cycles, widths correct.
